// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle CPU control unit
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
    OP_LW, OP_SW, OP_LLB, OP_LHB, OP_B, OP_BR, OP_PCS, OP_HLT
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB, ALU_XOR, ALU_RED, ALU_SLL, ALU_SRA, ALU_ROR, ALU_PADDSB
  } alu_op_e;

  typedef enum logic [1:0] {
    M2R_PC  = 2'b00,
    M2R_IMM = 2'b01,
    M2R_ALU = 2'b10,
    M2R_MEM = 2'b11
  } m2r_e;

  typedef enum logic [1:0] {
    PC_NEXT = 2'b00,
    PC_REG  = 2'b01,
    PC_REL  = 2'b11
  } pc_src_e;

  typedef enum logic [2:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_IMM, CL_BRANCH, CL_PCS, CL_HALT, CL_ILLEGAL
  } op_class_e;

  // Z,V,N write-enable masks
  localparam logic [2:0] FLAGS_ALL  = 3'b111;
  localparam logic [2:0] FLAGS_Z    = 3'b100;
  localparam logic [2:0] FLAGS_NONE = 3'b000;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - maps the latched IR to an opcode class and static datapath fields
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] ir,
  output logic [2:0]     op_class,
  output logic [2:0]     alu_op,
  output logic           alu_src,
  output logic [2:0]     flag_mask,
  output logic [1:0]     mem_to_reg,
  output logic [1:0]     pc_src,
  output logic           lh
);

  logic [3:0] op4;
  logic       illegal;

  assign op4     = ir[3:0];
  assign illegal = 32'(ir) > 32'd15;

  always_comb begin
    op_class   = CL_ILLEGAL;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    flag_mask  = FLAGS_NONE;
    mem_to_reg = M2R_PC;
    pc_src     = PC_NEXT;
    lh         = 1'b0;
    if (!illegal) begin
      case (op4)
        OP_ADD, OP_SUB: begin
          op_class = CL_ALU; alu_op = op4[2:0]; flag_mask = FLAGS_ALL; mem_to_reg = M2R_ALU;
        end
        OP_XOR, OP_RED, OP_PADDSB: begin
          op_class = CL_ALU; alu_op = op4[2:0]; flag_mask = FLAGS_Z; mem_to_reg = M2R_ALU;
        end
        OP_SLL, OP_SRA, OP_ROR: begin
          op_class = CL_ALU; alu_op = op4[2:0]; flag_mask = FLAGS_Z; mem_to_reg = M2R_ALU;
          alu_src = 1'b1;
        end
        OP_LW:  begin op_class = CL_LOAD;  alu_src = 1'b1; mem_to_reg = M2R_MEM; end
        OP_SW:  begin op_class = CL_STORE; alu_src = 1'b1; end
        OP_LLB: begin op_class = CL_IMM;   mem_to_reg = M2R_IMM; end
        OP_LHB: begin op_class = CL_IMM;   mem_to_reg = M2R_IMM; lh = 1'b1; end
        OP_B:   begin op_class = CL_BRANCH; pc_src = PC_REL; end
        OP_BR:  begin op_class = CL_BRANCH; pc_src = PC_REG; end
        OP_PCS: begin op_class = CL_PCS;   mem_to_reg = M2R_PC; end
        OP_HLT: op_class = CL_HALT;
        default: op_class = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control_mc.sv
// rtl/cpu_control_mc.sv - multi-cycle Moore control FSM for the 16-bit CPU
// Optional memory-wait watchdog enabled by defining CTRL_TIMEOUT_EN.
module cpu_control_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 4
`ifdef CTRL_TIMEOUT_EN
  ,
  parameter int MEM_WAIT_MAX = 15
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  input  logic           cond_met,
  output logic           ir_load,
  output logic           pc_write,
  output logic           reg_read,
  output logic           mem_read,
  output logic           mem_write,
  output logic [1:0]     mem_to_reg,
  output logic [2:0]     alu_op,
  output logic           alu_src,
  output logic           reg_write,
  output logic           lh,
  output logic [1:0]     pc_source,
  output logic [2:0]     flag_wr,
  output logic           illegal_op,
  output logic           mem_timeout,
  output logic           halted,
  output logic [2:0]     state
);

  state_e         st;
  logic [OPW-1:0] ir;
  logic [2:0]     cls;
  logic [2:0]     d_alu_op;
  logic           d_alu_src;
  logic [2:0]     d_flags;
  logic [1:0]     d_m2r;
  logic [1:0]     d_pc_src;
  logic           d_lh;
  logic           wd_fire;

  cpu_ctrl_decode #(.OPW(OPW)) u_decode (
    .ir         (ir),
    .op_class   (cls),
    .alu_op     (d_alu_op),
    .alu_src    (d_alu_src),
    .flag_mask  (d_flags),
    .mem_to_reg (d_m2r),
    .pc_src     (d_pc_src),
    .lh         (d_lh)
  );

`ifdef CTRL_TIMEOUT_EN
  logic       waiting;
  logic [7:0] wdog;
  logic       timeout_q;

  // The counter only survives consecutive stalled cycles; any progress clears it.
  assign waiting = ((st == S_FETCH) || (st == S_MEM)) && !mem_ready;
  assign wd_fire = waiting && ((wdog + 8'd1) == 8'(MEM_WAIT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wdog <= (waiting && !wd_fire) ? wdog + 8'd1 : 8'd0;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_FETCH;
      ir <= '0;
    end else if (wd_fire) begin
      st <= S_HALT;
    end else begin
      case (st)
        S_FETCH: if (mem_ready) begin
          ir <= opcode;
          st <= S_DECODE;
        end
        S_DECODE: case (cls)
          CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH: st <= S_EXEC;
          CL_IMM, CL_PCS:                       st <= S_WB;
          CL_HALT:                              st <= S_HALT;
          default:                              st <= S_FETCH;
        endcase
        S_EXEC: begin
          if (cls == CL_BRANCH) st <= S_FETCH;
          else if ((cls == CL_LOAD) || (cls == CL_STORE)) st <= S_MEM;
          else st <= S_WB;
        end
        S_MEM:  if (mem_ready) st <= (cls == CL_LOAD) ? S_WB : S_FETCH;
        S_WB:   st <= S_FETCH;
        S_HALT: st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Outputs are held at zero while rst is asserted so FETCH's read is not seen during reset.
  always_comb begin
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    reg_read   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_op     = 3'b000;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    lh         = 1'b0;
    pc_source  = PC_NEXT;
    flag_wr    = FLAGS_NONE;
    illegal_op = 1'b0;
    halted     = 1'b0;
    state      = S_FETCH;
    if (!rst) begin
      state = st;
      case (st)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_load  = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          reg_read   = 1'b1;
          illegal_op = (cls == CL_ILLEGAL);
        end
        S_EXEC: begin
          alu_op  = d_alu_op;
          alu_src = d_alu_src;
          flag_wr = d_flags;
          if (cls == CL_BRANCH) begin
            pc_write  = cond_met;
            pc_source = d_pc_src;
          end
        end
        S_MEM: begin
          mem_read  = (cls == CL_LOAD);
          mem_write = (cls == CL_STORE);
          alu_src   = 1'b1;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = d_m2r;
          lh         = d_lh;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_mc.sv
// tb/tb_cpu_control_mc.sv - self-checking bench for cpu_control_mc (OPW=5)
module tb_cpu_control_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic       mem_ready = 1'b0;
  logic       cond_met = 1'b0;
  logic       ir_load, pc_write, reg_read, mem_read, mem_write;
  logic [1:0] mem_to_reg;
  logic [2:0] alu_op;
  logic       alu_src, reg_write, lh;
  logic [1:0] pc_source;
  logic [2:0] flag_wr;
  logic       illegal_op, mem_timeout, halted;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_control_mc #(.OPW(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .cond_met(cond_met),
    .ir_load(ir_load), .pc_write(pc_write), .reg_read(reg_read), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .lh(lh), .pc_source(pc_source), .flag_wr(flag_wr),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .halted(halted), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ir_load;
    logic       pc_write;
    logic       reg_read;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] m2r;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       lh;
    logic [1:0] pcs;
    logic [2:0] flag;
    logic       illegal;
    logic       halted;
  } obs_t;

  typedef enum {PF, PD, PE, PM, PW, PH} ph_e;
  typedef struct { ph_e ph; logic rdy; } step_t;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic       cond;
    int         fw;
    int         mw;
    int         cyc;
    logic       rw;
    logic [1:0] m2r;
    logic [2:0] fl;
    logic       bp;
    logic       lhx;
    int         ill;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = state; o.ir_load = ir_load; o.pc_write = pc_write; o.reg_read = reg_read;
    o.mem_read = mem_read; o.mem_write = mem_write; o.m2r = mem_to_reg; o.alu_op = alu_op;
    o.alu_src = alu_src; o.reg_write = reg_write; o.lh = lh; o.pcs = pc_source;
    o.flag = flag_wr; o.illegal = illegal_op; o.halted = halted;
    return o;
  endfunction

  // Expected outputs for one cycle, straight from the per-phase rules of the ISA.
  function automatic obs_t model(input ph_e ph, input logic [4:0] op, input logic cond,
                                 input logic rdy);
    obs_t o = '0;
    case (ph)
      PF: begin o.st = 3'd0; o.mem_read = 1'b1; o.ir_load = rdy; o.pc_write = rdy; end
      PD: begin o.st = 3'd1; o.reg_read = 1'b1; o.illegal = (op > 5'd15); end
      PE: begin
        o.st = 3'd2;
        if (op < 5'd8) begin
          o.alu_op  = op[2:0];
          o.alu_src = (op >= 5'd4) && (op <= 5'd6);
          o.flag    = (op < 5'd2) ? 3'b111 : 3'b100;
        end else if (op == 5'd8 || op == 5'd9) begin
          o.alu_src = 1'b1;
        end else begin
          o.pc_write = cond;
          o.pcs      = (op == 5'd12) ? 2'b11 : 2'b01;
        end
      end
      PM: begin o.st = 3'd3; o.mem_read = (op == 5'd8); o.mem_write = (op == 5'd9); o.alu_src = 1'b1; end
      PW: begin
        o.st = 3'd4; o.reg_write = 1'b1; o.lh = (op == 5'd11);
        if (op < 5'd8) o.m2r = 2'b10;
        else if (op == 5'd8) o.m2r = 2'b11;
        else if (op == 5'd10 || op == 5'd11) o.m2r = 2'b01;
        else o.m2r = 2'b00;
      end
      PH: begin o.st = 3'd5; o.halted = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0; cond_met = 1'b0; opcode = 5'd0;
    repeat (2) @(negedge clk);
    mem_ready = 1'b1; cond_met = 1'b1; opcode = 5'h0F;
    #1;
    chk("reset_outputs", int'(sample()), 0);
    chk("reset_timeout", int'(mem_timeout), 0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0; cond_met = 1'b0; opcode = 5'd0;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge of the next FETCH/HALT.
  task automatic run_vec(input vec_t v);
    int cyc = 0, fwc = 0, mwc = 0, ill = 0;
    logic left = 1'b0, rw = 1'b0, bp = 1'b0, lhs = 1'b0;
    logic [1:0] m2r = 2'b00;
    logic [2:0] fl = 3'b000;
    cond_met = v.cond;
    do begin
      opcode = (state == 3'd0) ? v.op : 5'($urandom);
      if (state == 3'd0) begin mem_ready = (fwc == v.fw); fwc++; end
      else if (state == 3'd3) begin mem_ready = (mwc == v.mw); mwc++; end
      else mem_ready = 1'($urandom);
      #1;
      if (reg_write) begin rw = 1'b1; m2r = mem_to_reg; end
      lhs |= lh;
      fl  |= flag_wr;
      if (state != 3'd0 && pc_write) bp = 1'b1;
      ill += int'(illegal_op);
      cyc++;
      @(negedge clk);
      if (state != 3'd0) left = 1'b1;
    end while ((!left || state != 3'd0) && state != 3'd5 && cyc < 60);
    chk({v.name, "_cycles"}, cyc, v.cyc);
    chk({v.name, "_reg_write"}, int'(rw), int'(v.rw));
    chk({v.name, "_mem_to_reg"}, int'(m2r), int'(v.m2r));
    chk({v.name, "_flag_wr"}, int'(fl), int'(v.fl));
    chk({v.name, "_branch_pc_write"}, int'(bp), int'(v.bp));
    chk({v.name, "_lh"}, int'(lhs), int'(v.lhx));
    chk({v.name, "_illegal_pulses"}, ill, v.ill);
  endtask

  task automatic run_rand(input logic [4:0] op, input logic cond, input int fw, input int mw);
    step_t s[$];
    obs_t  exp_o;
    for (int i = 0; i < fw; i++) s.push_back('{PF, 1'b0});
    s.push_back('{PF, 1'b1});
    s.push_back('{PD, 1'($urandom)});
    if (op > 5'd15) begin
    end else if (op < 5'd8) begin
      s.push_back('{PE, 1'($urandom)}); s.push_back('{PW, 1'($urandom)});
    end else if (op == 5'd8 || op == 5'd9) begin
      s.push_back('{PE, 1'($urandom)});
      for (int i = 0; i < mw; i++) s.push_back('{PM, 1'b0});
      s.push_back('{PM, 1'b1});
      if (op == 5'd8) s.push_back('{PW, 1'($urandom)});
    end else if (op == 5'd12 || op == 5'd13) begin
      s.push_back('{PE, 1'($urandom)});
    end else if (op == 5'd15) begin
      for (int i = 0; i < 3; i++) s.push_back('{PH, 1'($urandom)});
    end else begin
      s.push_back('{PW, 1'($urandom)});
    end
    for (int i = 0; i < s.size(); i++) begin
      mem_ready = s[i].rdy;
      cond_met  = cond;
      opcode    = (s[i].ph == PF && s[i].rdy) ? op : 5'($urandom);
      #1;
      exp_o = model(s[i].ph, op, cond, s[i].rdy);
      chk($sformatf("rand_op%0h_step%0d", op, i), int'(sample()), int'(exp_o));
      @(negedge clk);
    end
    if (op == 5'd15) do_reset();
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"add",     5'h00, 1'b0, 0, 0, 4, 1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 0};
    vecs[1]  = '{"sub_fw2", 5'h01, 1'b0, 2, 0, 6, 1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 0};
    vecs[2]  = '{"sll",     5'h04, 1'b0, 0, 0, 4, 1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 0};
    vecs[3]  = '{"lw_mw3",  5'h08, 1'b0, 0, 3, 8, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 0};
    vecs[4]  = '{"sw_mw1",  5'h09, 1'b0, 0, 1, 5, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0};
    vecs[5]  = '{"llb",     5'h0A, 1'b0, 0, 0, 3, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 0};
    vecs[6]  = '{"lhb",     5'h0B, 1'b0, 0, 0, 3, 1'b1, 2'b01, 3'b000, 1'b0, 1'b1, 0};
    vecs[7]  = '{"pcs_fw1", 5'h0E, 1'b0, 1, 0, 4, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 0};
    vecs[8]  = '{"b_taken", 5'h0C, 1'b1, 0, 0, 3, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 0};
    vecs[9]  = '{"b_not",   5'h0C, 1'b0, 0, 0, 3, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0};
    vecs[10] = '{"br_taken",5'h0D, 1'b1, 0, 0, 3, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 0};
    vecs[11] = '{"illegal", 5'h13, 1'b0, 0, 0, 2, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1};

    do_reset();
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // HLT holds for 20 cycles regardless of mem_ready, then rst recovers
    mem_ready = 1'b1; opcode = 5'h0F;
    @(negedge clk); opcode = 5'd0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      #1;
      chk($sformatf("halt_hold_%0d", i), int'(sample()), int'(model(PH, 5'h0F, 1'b0, 1'b0)));
      @(negedge clk);
    end
    do_reset();

`ifdef CTRL_TIMEOUT_EN
    begin
      int k = 0;
      do begin
        mem_ready = 1'b0;
        #1;
        if (state == 3'd0) k++;
        @(negedge clk);
      end while (state == 3'd0 && k < 40);
      #1;
      chk("timeout_wait_cycles", k, 15);
      chk("timeout_flag", int'(mem_timeout), 1);
      chk("timeout_halted", int'(halted), 1);
      do_reset();
      repeat (7) begin mem_ready = 1'b0; @(negedge clk); end
      do_reset();
      repeat (14) begin mem_ready = 1'b0; @(negedge clk); end
      #1;
      chk("timeout_counter_cleared", int'(state), 0);
      chk("timeout_not_set", int'(mem_timeout), 0);
      @(negedge clk);
      #1;
      chk("timeout_after_15", int'(halted), 1);
      do_reset();
    end
`else
    repeat (20) begin mem_ready = 1'b0; @(negedge clk); end
    #1;
    chk("no_watchdog_still_fetch", int'(state), 0);
    chk("no_watchdog_timeout", int'(mem_timeout), 0);
    do_reset();
`endif

    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 19));
      run_rand(op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_control_mc.md
Name: cpu_control_mc

Overview:
- Multi-cycle control unit for the 16-bit CPU.
- Replaces the single-cycle opcode decoder with a registered Moore FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Waits on a memory-ready handshake and latches the opcode into an internal IR field.
- Drives datapath control per state; opcode width is parametrised for future ISA extension.

Parameters:
OPW, 4, opcode width; opcodes with any bit above bit 3 set are illegal
MEM_WAIT_MAX, 15, watchdog limit in cycles for a memory wait (only with CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  OPW  instruction opcode field from the memory read data
mem_ready  in  1  memory access completes this cycle
cond_met  in  1  branch condition true (from flag comparator)
ir_load  out  1  capture instruction word
pc_write  out  1  PC register update enable
reg_read  out  1  register file read enable
mem_read  out  1  data/instruction memory read
mem_write  out  1  data memory write
mem_to_reg  out  2  writeback select: 00 PC+2, 01 immediate, 10 ALU, 11 memory
alu_op  out  3  ALU operation
alu_src  out  1  1 selects immediate operand
reg_write  out  1  register write enable
lh  out  1  load-high select for LHB
pc_source  out  2  00 PC+2, 01 register, 11 PC-relative
flag_wr  out  3  Z,V,N flag write enables
illegal_op  out  1  one-cycle pulse on undefined opcode
mem_timeout  out  1  sticky watchdog error (0 when feature is off)
halted  out  1  FSM is in HALT
state  out  3  current state, for debug

Behaviour:
- Reset: state=FETCH, IR=0, all outputs 0, watchdog=0; rst has priority over all events, including mid-wait.
- Outputs are combinational from the registered state and IR. There are no latches, and none of the outputs is X.

FETCH:
- Asserts mem_read.
- Holds while mem_ready=0.
- On mem_ready=1: ir_load=1, pc_write=1, pc_source=00, then go to DECODE. IR takes opcode on the same edge.

DECODE:
- Asserts reg_read.
- Next state by IR:
  - 0x0-0x9: EXEC
  - 0xA (LLB), 0xB (LHB), 0xE (PCS): WB
  - 0xC (B), 0xD (BR): EXEC
  - 0xF (HLT): HALT
  - IR >= 16: pulse illegal_op, go to FETCH

EXEC:
- alu_op = IR[2:0] for 0x0-0x7; 000 for LW/SW.
- alu_src=1 for SLL, SRA, ROR, LW, SW.
- flag_wr:
  - ADD, SUB: 111
  - 0x2-0x7: 100
  - others: 000
- B/BR: pc_write=cond_met, pc_source=11 (B) or 01 (BR), then go to FETCH.
- LW/SW: go to MEM. Others: go to WB.

MEM:
- LW asserts mem_read; SW asserts mem_write. alu_src=1 is held.
- Holds while mem_ready=0.
- On mem_ready: LW goes to WB, SW goes to FETCH.

WB:
- reg_write=1, then go to FETCH.
- mem_to_reg: 10 for ALU ops, 11 for LW, 01 for LLB/LHB, 00 for PCS.
- lh=1 only for LHB.

HALT:
- halted=1; all enables are 0.
- Held until rst.

Latencies (fetch to next FETCH, zero wait states):
- ALU op: 4 cycles
- LW: 5 cycles
- SW: 4 cycles
- LLB/LHB/PCS: 3 cycles
- B/BR: 3 cycles
- Each wait cycle adds 1.

Optional Feature:
CTRL_TIMEOUT_EN:
- Defined:
  - An 8-bit watchdog counts consecutive cycles in FETCH/MEM with mem_ready=0.
  - It clears on mem_ready or on a state change.
  - When the count reaches MEM_WAIT_MAX, mem_timeout is set (sticky until rst) and the FSM goes to HALT.
- Undefined: waits forever; mem_timeout is tied to 0 and there is no counter logic.

Decomposition:
- Package cpu_ctrl_pkg:
  - state encoding (FETCH=0 … HALT=5)
  - opcode constants OP_ADD … OP_HLT
  - ALU op codes
  - mem_to_reg and pc_source codes
  - flag masks
- Sub-module cpu_ctrl_decode: combinational; maps IR to opcode class (alu, load, store, imm, branch, pcs, halt, illegal) plus static fields (alu_op, alu_src, flag mask, mem_to_reg, lh).
- The FSM stays in cpu_control_mc.

Test Plan:
- ADD (0x0), mem_ready high in FETCH → states FETCH, DECODE, EXEC, WB; flag_wr=111 in EXEC; reg_write=1 and mem_to_reg=10 in WB; 4 cycles.
- LW (0x8) with mem_ready low for 3 MEM cycles → MEM held 4 cycles; mem_read=1 throughout; then WB with mem_to_reg=11; 8 cycles total.
- B (0xC) with cond_met=1, then cond_met=0 → first: pc_write=1, pc_source=11 in EXEC; second: pc_write=0; both return to FETCH.
- HLT (0xF) → halted=1 and stays for 20 cycles with mem_ready toggling; rst then gives state=FETCH, all outputs 0.
- OPW=5, opcode=0x13 → illegal_op pulses for 1 cycle in DECODE; next state is FETCH; reg_write never asserted.
- CTRL_TIMEOUT_EN, MEM_WAIT_MAX=15, mem_ready stuck low in FETCH → mem_timeout=1 and HALT after 15 cycles. Same stimulus with rst at cycle 7 → clean FETCH, counter cleared.
